// File: rtl/chip8_instruction_fetch_pkg.sv
// Shared types for the Chip-8 instruction fetch stage.
package chip8_instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_W = 16;

endpackage

// File: rtl/chip8_instruction_fetch.sv
// Chip-8 fetch stage: reads the big-endian opcode pair at PC/PC+1 over a shared port.
// Optional misaligned-PC flag is built when CHIP8_FETCH_ALIGN_CHECK_EN is defined.
module chip8_instruction_fetch
  import chip8_instruction_fetch_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic                cpu_clk,
  input  logic                reset,
  input  logic                fetch_start,
  input  logic [ADDR_W-1:0]   PC_readdata,
  input  logic                mem_grant,
  input  logic [7:0]          mem_readdata1,
  input  logic [7:0]          mem_readdata2,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr1,
  output logic [ADDR_W-1:0]   mem_addr2,
  output logic [OPCODE_W-1:0] instruction,
  output logic                instr_valid,
  output logic                busy,
  output logic                fetch_error
);

  localparam int unsigned MEM_LATENCY_MIN = 1;
  localparam int unsigned MEM_LATENCY_MAX = 7;
  localparam logic [2:0]  CNT_INIT        = 3'(MEM_LATENCY);

  if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("MEM_LATENCY must be within 1..7");
  end

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [OPCODE_W-1:0]   instruction_q, instruction_d;
  logic                  instr_valid_q, instr_valid_d;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
  logic                  fetch_error_q, fetch_error_d;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    instruction_d = instruction_q;
    instr_valid_d = 1'b0;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    fetch_error_d = 1'b0;
`endif
    unique case (state_q)
      FETCH_IDLE: begin
        if (fetch_start) begin
          pc_d    = PC_readdata;
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (mem_grant) begin
          cnt_d   = CNT_INIT;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Data is valid on the edge where the latency countdown expires.
        if (cnt_q == 3'd1) begin
          instruction_d = {mem_readdata1, mem_readdata2};
          instr_valid_d = 1'b1;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
          fetch_error_d = pc_q[0];
`endif
          state_d       = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= '0;
      cnt_q         <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
      fetch_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
      fetch_error_q <= fetch_error_d;
`endif
    end
  end

  assign busy        = (state_q != FETCH_IDLE);
  assign mem_req     = busy;
  // Addresses are forced to zero outside a fetch; PC+1 wraps at the top of memory.
  assign mem_addr1   = busy ? pc_q : '0;
  assign mem_addr2   = busy ? (pc_q + ADDR_W'(1)) : '0;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
  assign fetch_error = fetch_error_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_instruction_fetch.sv
// Directed bench for chip8_instruction_fetch: one instance at latency 1, one at latency 3.
module tb_chip8_instruction_fetch;
  import chip8_instruction_fetch_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        mem_grant;
  logic [11:0] pc;
  logic        start_a, start_b;

  logic        a_req, a_valid, a_busy, a_err;
  logic [11:0] a_addr1, a_addr2;
  logic [15:0] a_instr;
  logic [7:0]  a_rd1, a_rd2;

  logic        b_req, b_valid, b_busy, b_err;
  logic [11:0] b_addr1, b_addr2;
  logic [15:0] b_instr;
  logic [7:0]  b_rd1, b_rd2;

  logic [7:0]  mem [0:4095];

  int checks = 0;
  int fails  = 0;
  int valid_cnt = 0;
  int snap;
  logic exp_err;

  always #5 cpu_clk = ~cpu_clk;

  assign a_rd1 = mem[a_addr1];
  assign a_rd2 = mem[a_addr2];
  assign b_rd1 = mem[b_addr1];
  assign b_rd2 = mem[b_addr2];

  chip8_instruction_fetch #(.MEM_LATENCY(1), .ADDR_W(12)) dut_a (
    .cpu_clk(cpu_clk), .reset(reset), .fetch_start(start_a), .PC_readdata(pc),
    .mem_grant(mem_grant), .mem_readdata1(a_rd1), .mem_readdata2(a_rd2),
    .mem_req(a_req), .mem_addr1(a_addr1), .mem_addr2(a_addr2),
    .instruction(a_instr), .instr_valid(a_valid), .busy(a_busy), .fetch_error(a_err)
  );

  chip8_instruction_fetch #(.MEM_LATENCY(3), .ADDR_W(12)) dut_b (
    .cpu_clk(cpu_clk), .reset(reset), .fetch_start(start_b), .PC_readdata(pc),
    .mem_grant(mem_grant), .mem_readdata1(b_rd1), .mem_readdata2(b_rd2),
    .mem_req(b_req), .mem_addr1(b_addr1), .mem_addr2(b_addr2),
    .instruction(b_instr), .instr_valid(b_valid), .busy(b_busy), .fetch_error(b_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  always @(negedge cpu_clk) if (a_valid === 1'b1) valid_cnt++;

  // Grant must stay high for the whole WAIT phase.
  always @(negedge cpu_clk)
    if (!reset && dut_a.state_q == FETCH_WAIT) check("grant_held_in_wait", 16'(mem_grant), 16'h1);

  initial begin
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h61; mem[12'h201] = 8'hF0; mem[12'h202] = 8'h0A;
    mem[12'h300] = 8'h7E; mem[12'h301] = 8'h54;
    mem[12'hFFF] = 8'hA2; mem[12'h000] = 8'h2A;
    mem[12'h400] = 8'h12; mem[12'h401] = 8'h34;
    mem[12'h402] = 8'h56; mem[12'h403] = 8'h78;

    reset = 1'b1; mem_grant = 1'b1; pc = 12'h200; start_a = 1'b0; start_b = 1'b0;
    tick(); tick();
    check("rst_mem_req", 16'(a_req), 16'h0);
    check("rst_busy", 16'(a_busy), 16'h0);
    check("rst_addr1", 16'(a_addr1), 16'h0);
    check("rst_addr2", 16'(a_addr2), 16'h0);
    check("rst_instr", a_instr, 16'h0000);
    check("rst_valid", 16'(a_valid), 16'h0);
    check("rst_err", 16'(a_err), 16'h0);
    reset = 1'b0;
    tick();

    // Basic fetch at 0x200, latency 1.
    pc = 12'h200; start_a = 1'b1;
    tick();                                   // E0
    start_a = 1'b0;
    check("t1_req", 16'(a_req), 16'h1);
    check("t1_busy", 16'(a_busy), 16'h1);
    check("t1_addr1", 16'(a_addr1), 16'h200);
    check("t1_addr2", 16'(a_addr2), 16'h201);
    tick();                                   // E1
    check("t1_valid_early", 16'(a_valid), 16'h0);
    check("t1_addr1_wait", 16'(a_addr1), 16'h200);
    tick();                                   // E2
    check("t1_valid", 16'(a_valid), 16'h1);
    check("t1_instr", a_instr, 16'h61F0);
    check("t1_req_off", 16'(a_req), 16'h0);
    check("t1_busy_off", 16'(a_busy), 16'h0);
    check("t1_addr1_off", 16'(a_addr1), 16'h0);
    check("t1_addr2_off", 16'(a_addr2), 16'h0);
    tick();
    check("t1_valid_pulse", 16'(a_valid), 16'h0);
    check("t1_instr_hold", a_instr, 16'h61F0);

    // Grant withheld for 3 cycles; PC changes mid-fetch must not matter.
    pc = 12'h300; mem_grant = 1'b0; start_a = 1'b1;
    tick();                                   // E0
    start_a = 1'b0; pc = 12'h123;
    for (int i = 0; i < 3; i++) begin
      check("t2_req_held", 16'(a_req), 16'h1);
      check("t2_addr1_held", 16'(a_addr1), 16'h300);
      check("t2_valid_early", 16'(a_valid), 16'h0);
      tick();                                 // E1..E3
    end
    mem_grant = 1'b1;
    check("t2_addr2_held", 16'(a_addr2), 16'h301);
    tick();                                   // E4
    check("t2_valid_e4", 16'(a_valid), 16'h0);
    tick();                                   // E5
    check("t2_valid", 16'(a_valid), 16'h1);
    check("t2_instr", a_instr, 16'h7E54);
    tick();

    // Address wrap at 0xFFF.
    pc = 12'hFFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t3_addr1", 16'(a_addr1), 16'hFFF);
    check("t3_addr2_wrap", 16'(a_addr2), 16'h000);
    tick(); tick();
    check("t3_valid", 16'(a_valid), 16'h1);
    check("t3_instr", a_instr, 16'hA22A);
    tick();

    // Latency 3 instance.
    pc = 12'h200; start_b = 1'b1;
    tick();                                   // E0
    start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();                                 // E1..E3
      check("t4_valid_early", 16'(b_valid), 16'h0);
      check("t4_busy", 16'(b_busy), 16'h1);
    end
    tick();                                   // E4
    check("t4_valid", 16'(b_valid), 16'h1);
    check("t4_instr", b_instr, 16'h61F0);
    check("t4_a_untouched", a_instr, 16'hA22A);
    tick();

    // Start held while busy is ignored: exactly one pulse.
    snap = valid_cnt;
    pc = 12'h400; start_a = 1'b1;
    tick();                                   // E0 accepted
    tick();                                   // E1 ignored (busy)
    start_a = 1'b0;
    tick();                                   // E2 valid
    check("t5_instr", a_instr, 16'h1234);
    tick(); tick(); tick(); tick();
    check("t5_one_pulse", 16'(valid_cnt - snap), 16'h1);
    check("t5_idle", 16'(a_busy), 16'h0);

    // Back-to-back: new start on the instr_valid cycle.
    snap = valid_cnt;
    pc = 12'h200; start_a = 1'b1;
    tick();                                   // E0
    start_a = 1'b0;
    tick();                                   // E1
    tick();                                   // E2 valid
    check("t6_first_valid", 16'(a_valid), 16'h1);
    check("t6_first_instr", a_instr, 16'h61F0);
    pc = 12'h402; start_a = 1'b1;
    tick();                                   // E3 accepted
    start_a = 1'b0;
    check("t6_second_busy", 16'(a_busy), 16'h1);
    check("t6_second_addr", 16'(a_addr1), 16'h402);
    tick();
    tick();                                   // E5 valid
    check("t6_second_valid", 16'(a_valid), 16'h1);
    check("t6_second_instr", a_instr, 16'h5678);
    tick();
    check("t6_two_pulses", 16'(valid_cnt - snap), 16'h2);

    // Reset while in WAIT aborts the fetch.
    snap = valid_cnt;
    pc = 12'h300; start_a = 1'b1;
    tick();                                   // E0
    start_a = 1'b0;
    tick();                                   // E1 -> WAIT
    reset = 1'b1;
    tick();                                   // E2 reset
    check("t7_req", 16'(a_req), 16'h0);
    check("t7_busy", 16'(a_busy), 16'h0);
    check("t7_addr1", 16'(a_addr1), 16'h0);
    check("t7_addr2", 16'(a_addr2), 16'h0);
    check("t7_instr", a_instr, 16'h0000);
    check("t7_valid", 16'(a_valid), 16'h0);
    reset = 1'b0;
    tick(); tick();
    check("t7_no_pulse", 16'(valid_cnt - snap), 16'h0);

    // Odd PC completes; error flag only in the alignment-check build.
    pc = 12'h201; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t8_err_early", 16'(a_err), 16'h0);
    tick(); tick();
    check("t8_valid", 16'(a_valid), 16'h1);
    check("t8_instr", a_instr, 16'hF00A);
    check("t8_err", 16'(a_err), 16'(exp_err));
    tick();
    check("t8_err_pulse", 16'(a_err), 16'h0);

    tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
